// File: rtl/discrete_filter_scheduler.sv
// Time-multiplexed chain of first-order RC filter stages (LP / HP / bypass)
// sharing a single multiplier. One input sample per audio_clk_en is walked
// through all stages; every stage costs a MUL and an ACC cycle, then a DONE
// cycle publishes the result on out with a one-cycle out_valid pulse.
module discrete_filter_scheduler #(
  parameter int NUM_STAGES   = 4,
  parameter int SIGNAL_WIDTH = 16,
  parameter int COEF_WIDTH   = 16
) (
  input  logic                                              clk,
  input  logic                                              I_RST,
  input  logic                                              audio_clk_en,
  input  logic [SIGNAL_WIDTH-1:0]                           in,
  input  logic                                              cfg_we,
  input  logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] cfg_addr,
  input  logic [COEF_WIDTH-1:0]                             cfg_coef,
  input  logic [1:0]                                        cfg_mode,
  output logic [SIGNAL_WIDTH-1:0]                           out,
  output logic                                              out_valid,
  output logic                                              busy,
  output logic                                              overrun
);

  localparam int ADDR_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int DIFF_W = SIGNAL_WIDTH + 1;
  localparam int PROD_W = DIFF_W + COEF_WIDTH + 1;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(NUM_STAGES - 1);
  localparam logic [ADDR_W:0]   STAGE_CNT = (ADDR_W + 1)'(NUM_STAGES);

  localparam logic [1:0] MODE_LP  = 2'd0;
  localparam logic [1:0] MODE_HP  = 2'd1;
  localparam logic [1:0] MODE_BYP = 2'd2;

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (SIGNAL_WIDTH - 1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Clamp a wide intermediate into the signed sample range.
  function automatic logic signed [SIGNAL_WIDTH-1:0] sat_sig(
    input logic signed [SUM_W-1:0] v
  );
    if (v > SAT_MAX) begin
      sat_sig = SAT_MAX[SIGNAL_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      sat_sig = SAT_MIN[SIGNAL_WIDTH-1:0];
    end else begin
      sat_sig = v[SIGNAL_WIDTH-1:0];
    end
  endfunction

  state_t                         state;
  logic [ADDR_W-1:0]              k_p0;
  logic signed [SIGNAL_WIDTH-1:0] x_p0;
  logic signed [PROD_W-1:0]       prod_p1;

  logic signed [SIGNAL_WIDTH-1:0] y_p0     [NUM_STAGES];
  logic [COEF_WIDTH-1:0]          coef_live[NUM_STAGES];
  logic [1:0]                     mode_live[NUM_STAGES];
  logic [COEF_WIDTH-1:0]          coef_sh  [NUM_STAGES];
  logic [1:0]                     mode_sh  [NUM_STAGES];

  logic signed [SIGNAL_WIDTH-1:0] y_cur;
  logic [COEF_WIDTH-1:0]          coef_cur;
  logic [1:0]                     mode_cur;
  logic signed [DIFF_W-1:0]       diff;
  logic signed [PROD_W-1:0]       prod_nxt;
  logic signed [SUM_W-1:0]        acc;
  logic signed [SIGNAL_WIDTH-1:0] yn;
  logic signed [SIGNAL_WIDTH-1:0] hp_out;
  logic signed [SIGNAL_WIDTH-1:0] stage_out;

  // Shared datapath for the stage selected by k: difference, product, update.
  always_comb begin
    y_cur     = y_p0[k_p0];
    coef_cur  = coef_sh[k_p0];
    mode_cur  = mode_sh[k_p0];
    // p0 -> p1: difference feeding the shared multiplier
    diff      = DIFF_W'(x_p0) - DIFF_W'(y_cur);
    prod_nxt  = diff * $signed({1'b0, coef_cur});
    // p1 -> state: scale by alpha (floor), accumulate, saturate
    acc       = SUM_W'(y_cur) + SUM_W'(prod_p1 >>> COEF_WIDTH);
    yn        = sat_sig(acc);
    hp_out    = sat_sig(SUM_W'(x_p0) - SUM_W'(yn));
    case (mode_cur)
      MODE_LP: stage_out = yn;
      MODE_HP: stage_out = hp_out;
      default: stage_out = x_p0;
    endcase
  end

  // Live configuration registers, writable at any cycle for valid stage indices.
  always_ff @(posedge clk) begin
    if (I_RST) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        coef_live[i] <= '0;
        mode_live[i] <= MODE_BYP;
      end
    end else if (cfg_we && ({1'b0, cfg_addr} < STAGE_CNT)) begin
      coef_live[cfg_addr] <= cfg_coef;
      mode_live[cfg_addr] <= cfg_mode;
    end
  end

  // Sequencer: accept a sample, walk MUL/ACC per stage, publish in DONE.
  // out/out_valid are loaded on the edge into DONE so the pulse spans DONE.
  always_ff @(posedge clk) begin
    if (I_RST) begin
      state     <= IDLE;
      k_p0      <= '0;
      x_p0      <= '0;
      prod_p1   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        y_p0[i]    <= '0;
        coef_sh[i] <= '0;
        mode_sh[i] <= MODE_BYP;
      end
    end else begin
      out_valid <= 1'b0;
      if (audio_clk_en && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (audio_clk_en) begin
            x_p0    <= $signed(in);
            coef_sh <= coef_live;
            mode_sh <= mode_live;
            k_p0    <= '0;
            busy    <= 1'b1;
            state   <= MUL;
          end
        end
        MUL: begin
          prod_p1 <= prod_nxt;
          state   <= ACC;
        end
        ACC: begin
          if (!mode_cur[1]) begin
            y_p0[k_p0] <= yn;
          end
          x_p0 <= stage_out;
          if (k_p0 == LAST_K) begin
            out       <= stage_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k_p0  <= k_p0 + 1'b1;
            state <= MUL;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
